// File: rtl/sr_latch_bank_pkg.sv
// Shared types and helpers for the synchronous SR latch bank.
// Holds the conflict-resolution policy enum and filter-counter sizing.
package sr_pkg;

  typedef enum logic [1:0] {
    SET_DOM   = 2'd0,
    RESET_DOM = 2'd1,
    HOLD      = 2'd2,
    TOGGLE    = 2'd3
  } policy_t;

  localparam int MAX_FILTER = 15;

  // The counter must reach FILTER+1, so it needs room for values 0..FILTER+1.
  function automatic int cnt_width(input int filter);
    return $clog2(filter + 2);
  endfunction

endpackage

// File: rtl/sr_latch_bank_if.sv
// Control/status bus of the SR latch bank.
// Level-based bus with no valid/ready: s/r/clr_err are sampled on every rising
// clock edge and q/nq/err/changed are registered levels valid every cycle.
interface sr_latch_bank_if #(
  parameter int N = 4
);
  logic [N-1:0] s;
  logic [N-1:0] r;
  logic         clr_err;
  logic [N-1:0] q;
  logic [N-1:0] nq;
  logic [N-1:0] err;
  logic [N-1:0] changed;

  modport master (
    output s, r, clr_err,
    input  q, nq, err, changed
  );

  modport slave (
    input  s, r, clr_err,
    output q, nq, err, changed
  );
endinterface

// File: rtl/sr_latch_bank_channel.sv
// One filtered set/reset storage channel: a request must persist FILTER+1
// sampled edges, then acts exactly once; S=R=1 is resolved by POLICY.
module sr_channel
  import sr_pkg::*;
#(
  parameter int      FILTER = 2,
  parameter policy_t POLICY = RESET_DOM
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  input  logic clr_err,
  output logic q,
  output logic nq,
  output logic err,
  output logic changed
);

  localparam int            CW      = cnt_width(FILTER);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER + 1);

  logic [1:0]    req;
  logic [1:0]    last_req;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          qualify;
  logic          q_r;
  logic          q_nxt;
  logic          err_r;
  logic          err_nxt;
  logic          chg_r;

  always_comb begin
    req     = {s, r};
    cnt_nxt = '0;
    if (req == 2'b00)          cnt_nxt = '0;
    else if (req != last_req)  cnt_nxt = CW'(1);
    else if (cnt == CNT_MAX)   cnt_nxt = cnt;
    else                       cnt_nxt = cnt + CW'(1);

    // Only the edge that moves the counter onto CNT_MAX acts; a saturated,
    // unchanged request is already spent.
    qualify = (req != 2'b00) && (cnt_nxt == CNT_MAX) &&
              ((cnt != CNT_MAX) || (req != last_req));

    q_nxt = q_r;
    if (qualify) begin
      case (req)
        2'b10:   q_nxt = 1'b1;
        2'b01:   q_nxt = 1'b0;
        2'b11: begin
          case (POLICY)
            SET_DOM:   q_nxt = 1'b1;
            RESET_DOM: q_nxt = 1'b0;
            HOLD:      q_nxt = q_r;
            TOGGLE:    q_nxt = ~q_r;
            default:   q_nxt = q_r;
          endcase
        end
        default: q_nxt = q_r;
      endcase
    end

    // A conflict qualifying on the clear edge wins over clr_err.
    err_nxt = (qualify && (req == 2'b11)) || (err_r && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      last_req <= 2'b00;
      q_r      <= 1'b0;
      err_r    <= 1'b0;
      chg_r    <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      last_req <= req;
      q_r      <= q_nxt;
      err_r    <= err_nxt;
      chg_r    <= q_nxt ^ q_r;
    end
  end

  assign q       = q_r;
  assign nq      = ~q_r;
  assign err     = err_r;
  assign changed = chg_r;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of N independent filtered SR channels sharing one clock, reset and
// a global error clear.
module sr_latch_bank
  import sr_pkg::*;
#(
  parameter int      N      = 4,
  parameter int      FILTER = 2,
  parameter policy_t POLICY = RESET_DOM
) (
  input  logic            clk,
  input  logic            reset,
  sr_latch_bank_if.slave  bus
);

  logic [N-1:0] q_v;
  logic [N-1:0] nq_v;
  logic [N-1:0] err_v;
  logic [N-1:0] chg_v;

  for (genvar i = 0; i < N; i++) begin : g_ch
    sr_channel #(
      .FILTER (FILTER),
      .POLICY (POLICY)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .s       (bus.s[i]),
      .r       (bus.r[i]),
      .clr_err (bus.clr_err),
      .q       (q_v[i]),
      .nq      (nq_v[i]),
      .err     (err_v[i]),
      .changed (chg_v[i])
    );
  end

  assign bus.q       = q_v;
  assign bus.nq      = nq_v;
  assign bus.err     = err_v;
  assign bus.changed = chg_v;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Bench for sr_latch_bank: four N=4/FILTER=2 banks (one per policy) and one
// N=1/FILTER=0 bank share stimulus and are checked against a run-length model.
module tb_sr_latch_bank;
  import sr_pkg::*;

  localparam int ND = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s;
  logic [3:0] r;
  logic       clr_err;

  logic [3:0] dq   [ND];
  logic [3:0] dnq  [ND];
  logic [3:0] derr [ND];
  logic [3:0] dchg [ND];

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_latch_bank_if #(.N(4)) bus ();
    assign bus.s       = s;
    assign bus.r       = r;
    assign bus.clr_err = clr_err;
    sr_latch_bank #(
      .N      (4),
      .FILTER (2),
      .POLICY (policy_t'(g))
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
    assign dq[g]   = bus.q;
    assign dnq[g]  = bus.nq;
    assign derr[g] = bus.err;
    assign dchg[g] = bus.changed;
  end

  sr_latch_bank_if #(.N(1)) bus4 ();
  assign bus4.s       = s[0:0];
  assign bus4.r       = r[0:0];
  assign bus4.clr_err = clr_err;
  sr_latch_bank #(
    .N      (1),
    .FILTER (0),
    .POLICY (SET_DOM)
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );
  assign dq[4]   = {3'b000, bus4.q};
  assign dnq[4]  = {3'b000, bus4.nq};
  assign derr[4] = {3'b000, bus4.err};
  assign dchg[4] = {3'b000, bus4.changed};

  // ---------------- reference model ----------------
  // run = number of consecutive edges the same nonzero request has been seen;
  // an action fires when the run length is exactly FILTER+1.
  int pol  [ND] = '{0, 1, 2, 3, 0};
  int filt [ND] = '{2, 2, 2, 2, 0};
  int nch  [ND] = '{4, 4, 4, 4, 1};

  int       run   [ND][4];
  bit [1:0] lastr [ND][4];
  bit       mq    [ND][4];
  bit       merr  [ND][4];
  bit       mchg  [ND][4];

  task automatic model_step();
    for (int p = 0; p < ND; p++) begin
      for (int c = 0; c < 4; c++) begin
        bit [1:0] req;
        bit       nqv;
        bit       fire;
        req = {s[c], r[c]};
        if (reset || c >= nch[p]) begin
          run[p][c] = 0; lastr[p][c] = 2'b00;
          mq[p][c] = 1'b0; merr[p][c] = 1'b0; mchg[p][c] = 1'b0;
        end else begin
          if (req == 2'b00)              run[p][c] = 0;
          else if (req == lastr[p][c])   run[p][c] = (run[p][c] < 1000) ? run[p][c] + 1 : 1000;
          else                           run[p][c] = 1;
          fire = (req != 2'b00) && (run[p][c] == filt[p] + 1);
          nqv  = mq[p][c];
          if (fire) begin
            if (req == 2'b10)      nqv = 1'b1;
            else if (req == 2'b01) nqv = 1'b0;
            else if (pol[p] == 0)  nqv = 1'b1;
            else if (pol[p] == 1)  nqv = 1'b0;
            else if (pol[p] == 3)  nqv = ~mq[p][c];
          end
          if (fire && req == 2'b11) merr[p][c] = 1'b1;
          else if (clr_err)         merr[p][c] = 1'b0;
          mchg[p][c]  = (nqv != mq[p][c]);
          mq[p][c]    = nqv;
          lastr[p][c] = req;
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [3:0] pack(input int p, input int kind);
    logic [3:0] v;
    v = '0;
    for (int c = 0; c < nch[p]; c++) begin
      case (kind)
        0: v[c] = mq[p][c];
        1: v[c] = ~mq[p][c];
        2: v[c] = merr[p][c];
        default: v[c] = mchg[p][c];
      endcase
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      for (int p = 0; p < ND; p++) begin
        chk($sformatf("model_q[%0d]", p),   {28'b0, dq[p]},   {28'b0, pack(p, 0)});
        chk($sformatf("model_nq[%0d]", p),  {28'b0, dnq[p]},  {28'b0, pack(p, 1)});
        chk($sformatf("model_err[%0d]", p), {28'b0, derr[p]}, {28'b0, pack(p, 2)});
        chk($sformatf("model_chg[%0d]", p), {28'b0, dchg[p]}, {28'b0, pack(p, 3)});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    bit exp_pol [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit exp_chg [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1'b1; s = '0; r = '0; clr_err = 1'b0;
    cyc(2);
    reset = 1'b0;
    check_en = 1'b1;
    chk("reset_q",   {28'b0, dq[1]},   32'h0);
    chk("reset_nq",  {28'b0, dnq[1]},  32'hF);
    chk("reset_err", {28'b0, derr[1]}, 32'h0);
    chk("reset_chg", {28'b0, dchg[1]}, 32'h0);
    cyc(10);
    chk("idle_q", {28'b0, dq[1]}, 32'h0);

    // set, release, reset on ch0
    s = 4'b0001; cyc(2);
    chk("set_not_yet", {28'b0, dq[1]}, 32'h0);
    cyc(1);
    chk("set_q",   {28'b0, dq[1]},   32'h1);
    chk("set_chg", {28'b0, dchg[1]}, 32'h1);
    cyc(1);
    chk("set_chg_end", {28'b0, dchg[1]}, 32'h0);
    s = 4'b0000; cyc(3);
    chk("release_q", {28'b0, dq[1]}, 32'h1);
    r = 4'b0001; cyc(3);
    chk("reset_ch0_q", {28'b0, dq[1]}, 32'h0);
    r = 4'b0000; cyc(2);

    // glitch rejection on ch1
    s = 4'b0010; cyc(2); s = 4'b0000; cyc(2);
    chk("glitch_q", {28'b0, dq[1]}, 32'h0);
    s = 4'b0010; cyc(3);
    chk("glitch_then_set_q", {28'b0, dq[1]}, 32'h2);
    s = 4'b0000; cyc(1);

    // conflict policies on ch0 with q[0] preset to 1
    s = 4'b0001; cyc(3); s = 4'b0000; cyc(1);
    s = 4'b0001; r = 4'b0001; cyc(3);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("policy_q0[%0d]", p),   {31'b0, dq[p][0]},   {31'b0, exp_pol[p]});
      chk($sformatf("policy_err0[%0d]", p), {31'b0, derr[p][0]}, 32'h1);
      chk($sformatf("policy_chg0[%0d]", p), {31'b0, dchg[p][0]}, {31'b0, exp_chg[p]});
    end
    cyc(20);
    chk("toggle_once_q0", {31'b0, dq[3][0]}, 32'h0);
    s = 4'b0000; r = 4'b0000; cyc(1);
    clr_err = 1'b1; cyc(1); clr_err = 1'b0;
    for (int p = 0; p < 4; p++)
      chk($sformatf("clr_err[%0d]", p), {28'b0, derr[p]}, 32'h0);

    // reset in the middle of a filter run
    s = 4'b0010; cyc(2);
    reset = 1'b1; cyc(1);
    chk("midreset_q", {28'b0, dq[1]}, 32'h0);
    reset = 1'b0; cyc(2);
    chk("midreset_wait_q", {28'b0, dq[1]}, 32'h0);
    cyc(1);
    chk("midreset_set_q", {28'b0, dq[1]}, 32'h2);
    s = 4'b0000; cyc(1);

    // FILTER=0 single-channel bank
    s = 4'b0001; cyc(1);
    chk("f0_q",   {28'b0, dq[4]},   32'h1);
    chk("f0_chg", {28'b0, dchg[4]}, 32'h1);
    s = 4'b0000; cyc(1);
    s = 4'b0001; r = 4'b0001; clr_err = 1'b1; cyc(1);
    chk("f0_clr_vs_conflict_err", {28'b0, derr[4]}, 32'h1);
    s = 4'b0000; r = 4'b0000; clr_err = 1'b0; cyc(1);

    // randomized phase: requests change sparsely so many of them qualify
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int c;
        c = $urandom_range(0, 3);
        s[c] = 1'($urandom_range(0, 1));
        r[c] = 1'($urandom_range(0, 1));
      end
      clr_err = ($urandom_range(0, 24) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    reset = 1'b0; clr_err = 1'b0; s = '0; r = '0;
    cyc(2);
    check_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
